// File: rtl/md5_gen_pkg.sv
// Shared constants and state encoding for the MD5 candidate generator.
package md5_gen_pkg;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam int DEF_LANES  = 3;
  localparam int DEF_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/md5_cand_gen_ascii_dec_add.sv
// Combinational ASCII-decimal adder: adds a 0..9 addend to the least
// significant character and ripples the carry through the whole string.
module ascii_dec_add import md5_gen_pkg::*; #(
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic [DIGITS*8-1:0] din,
  input  logic [3:0]          addend,
  output logic [DIGITS*8-1:0] sum,
  output logic                carry_out
);
  logic [7:0] s;
  logic       c;

  // Working on the raw byte keeps every result inside '0'..'9':
  // at most 8'h39 + 9 + 1 = 8'h43, pulled back by 10 on carry.
  always_comb begin
    c   = 1'b0;
    s   = '0;
    sum = din;
    for (int i = 0; i < DIGITS; i++) begin
      s = din[i*8 +: 8] + ((i == 0) ? {4'b0, addend} : 8'd0) + {7'b0, c};
      if (s > ASCII_NINE) begin
        s = s - 8'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      sum[i*8 +: 8] = s;
    end
    carry_out = c;
  end
endmodule

// File: rtl/md5_cand_gen.sv
// Candidate producer: LANES ASCII decimal passwords per beat, valid/ready out.
// Optional issued-candidate counter under `define MD5_CAND_COUNT_EN.
module md5_cand_gen import md5_gen_pkg::*; #(
  parameter int LANES  = DEF_LANES,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      stop,
  output logic                      cand_valid,
  input  logic                      cand_ready,
  output logic [LANES*DIGITS*8-1:0] cand_data,
  output logic [LANES-1:0]          lane_mask,
  output logic                      busy,
  output logic                      exhausted
`ifdef MD5_CAND_COUNT_EN
  ,
  output logic [31:0]               issued_cnt
`endif
);
  localparam logic [3:0] ADD = 4'(LANES);

  state_t                               state;
  logic [LANES-1:0][DIGITS*8-1:0]       lane_q, lane_nxt, lane_init;
  logic [LANES-1:0]                     wrap, carry, wrap_nxt;

  assign cand_data = lane_q;
  assign wrap_nxt  = wrap | carry;

  always_comb begin
    lane_init = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_init[k]       = {DIGITS{ASCII_ZERO}};
      lane_init[k][7:0]  = ASCII_ZERO + 8'(k);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ascii_dec_add #(.DIGITS(DIGITS)) u_add (
      .din      (lane_q[k]),
      .addend   (ADD),
      .sum      (lane_nxt[k]),
      .carry_out(carry[k])
    );
  end

`ifdef MD5_CAND_COUNT_EN
  logic [32:0] cnt_sum;
  assign cnt_sum = {1'b0, issued_cnt} + 33'($countones(lane_mask));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cand_valid <= 1'b0;
      busy       <= 1'b0;
      exhausted  <= 1'b0;
      lane_mask  <= '0;
      wrap       <= '0;
      for (int k = 0; k < LANES; k++) lane_q[k] <= {DIGITS{ASCII_ZERO}};
`ifdef MD5_CAND_COUNT_EN
      issued_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state      <= RUN;
          lane_q     <= lane_init;
          wrap       <= '0;
          lane_mask  <= '1;
          cand_valid <= 1'b1;
          busy       <= 1'b1;
          exhausted  <= 1'b0;
`ifdef MD5_CAND_COUNT_EN
          issued_cnt <= '0;
`endif
        end
        RUN: begin
          // stop wins over a same-cycle handshake: that beat is not advanced
          if (stop) begin
            state      <= IDLE;
            cand_valid <= 1'b0;
            busy       <= 1'b0;
            lane_mask  <= '0;
          end else if (cand_ready) begin
            for (int k = 0; k < LANES; k++)
              if (!wrap[k]) lane_q[k] <= lane_nxt[k];
            wrap <= wrap_nxt;
`ifdef MD5_CAND_COUNT_EN
            issued_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
`endif
            if (&wrap_nxt) begin
              state      <= DONE;
              cand_valid <= 1'b0;
              busy       <= 1'b0;
              lane_mask  <= '0;
              exhausted  <= 1'b1;
            end else begin
              lane_mask  <= ~wrap_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md5_cand_gen.sv
// Bench: two instances (8-digit and 2-digit, 3 lanes) driven in lockstep,
// checked every cycle against an integer-counter model plus literal vectors.
module tb_md5_cand_gen;
  logic clk, reset_n, start, stop, cand_ready;
  logic v8, v2, busy8, busy2, exh8, exh2;
  logic [191:0] c8;
  logic [47:0]  c2;
  logic [2:0]   m8, m2;
`ifdef MD5_CAND_COUNT_EN
  logic [31:0]  n8, n2;
`endif

  md5_cand_gen #(.LANES(3), .DIGITS(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .cand_valid(v8), .cand_ready(cand_ready), .cand_data(c8),
    .lane_mask(m8), .busy(busy8), .exhausted(exh8)
`ifdef MD5_CAND_COUNT_EN
    , .issued_cnt(n8)
`endif
  );

  md5_cand_gen #(.LANES(3), .DIGITS(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .cand_valid(v2), .cand_ready(cand_ready), .cand_data(c2),
    .lane_mask(m2), .busy(busy2), .exhausted(exh2)
`ifdef MD5_CAND_COUNT_EN
    , .issued_cnt(n2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] asc(input int v, input int d);
    logic [63:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < d; i++) begin
      r[i*8 +: 8] = 8'h30 + 8'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model: a running flag and the integer value of lane 0 per instance.
  int     maxv [2] = '{100000000, 100};
  int     digs [2] = '{8, 2};
  bit     m_run [2] = '{0, 0};
  int     m_base[2] = '{0, 0};
  bit     m_exh [2] = '{0, 0};
  longint m_cnt [2] = '{0, 0};

  function automatic logic [2:0] exp_mask(input int i);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) r[k] = m_run[i] && (m_base[i] + k < maxv[i]);
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_base[i] = 0; m_exh[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_run[i]) begin
          if (stop) m_run[i] = 0;
          else if (cand_ready) begin
            m_cnt[i] += $countones(exp_mask(i));
            m_base[i] += 3;
            if (m_base[i] >= maxv[i]) begin m_run[i] = 0; m_exh[i] = 1; end
          end
        end else if (start) begin
          m_run[i] = 1; m_base[i] = 0; m_exh[i] = 0; m_cnt[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] em;
    chk("valid8", {63'b0, v8}, {63'b0, m_run[0]});
    chk("valid2", {63'b0, v2}, {63'b0, m_run[1]});
    chk("busy8", {63'b0, busy8}, {63'b0, m_run[0]});
    chk("busy2", {63'b0, busy2}, {63'b0, m_run[1]});
    chk("exh8", {63'b0, exh8}, {63'b0, m_exh[0]});
    chk("exh2", {63'b0, exh2}, {63'b0, m_exh[1]});
    em = exp_mask(0);
    chk("mask8", {61'b0, m8}, {61'b0, em});
    for (int k = 0; k < 3; k++)
      if (em[k]) chk("data8", c8[k*64 +: 64], asc(m_base[0] + k, digs[0]));
    em = exp_mask(1);
    chk("mask2", {61'b0, m2}, {61'b0, em});
    for (int k = 0; k < 3; k++)
      if (em[k]) chk("data2", {48'b0, c2[k*16 +: 16]}, asc(m_base[1] + k, digs[1]));
`ifdef MD5_CAND_COUNT_EN
    chk("cnt8", {32'b0, n8}, m_cnt[0]);
    chk("cnt2", {32'b0, n2}, m_cnt[1]);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  logic [63:0] lit;
  bit [99:0]   seen;
  int          beats, distinct, v;
  bit          fin;

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; cand_ready = 1'b0;
    cyc(2);
    lit = "00000000";
    chk("rst_lane0", c8[63:0], lit);
    chk("rst_lane2", c8[191:128], lit);
    chk("rst_valid", {63'b0, v8}, 64'd0);
    reset_n = 1'b1;
    cyc(1);

    // Beats 0 and 1
    cand_ready = 1'b1;
    pulse_start();
    lit = "00000000"; chk("t1_b0_l0", c8[63:0], lit);
    lit = "00000002"; chk("t1_b0_l2", c8[191:128], lit);
    chk("t1_b0_mask", {61'b0, m8}, 64'd7);
    cyc(1);
    lit = "00000003"; chk("t1_b1_l0", c8[63:0], lit);
    lit = "00000005"; chk("t1_b1_l2", c8[191:128], lit);
    chk("t1_busy", {63'b0, busy8}, 64'd1);

    // Stall with lanes at 12..14; start while running must be ignored
    cyc(3);
    cand_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lit = "00000012"; chk("t2_hold_l0", c8[63:0], lit);
      lit = "00000014"; chk("t2_hold_l2", c8[191:128], lit);
      chk("t2_hold_mask", {61'b0, m8}, 64'd7);
      cyc(1);
      start = 1'b0;
    end
    cand_ready = 1'b1;
    cyc(1);
    lit = "00000015"; chk("t2_resume_l0", c8[63:0], lit);
    lit = "00000017"; chk("t2_resume_l2", c8[191:128], lit);

    // stop together with a handshake at 9..11
    pulse_stop();
    pulse_start();
    cyc(3);
    lit = "00000009"; chk("t4_pre_l0", c8[63:0], lit);
    pulse_stop();
    chk("t4_valid", {63'b0, v8}, 64'd0);
    chk("t4_exh", {63'b0, exh8}, 64'd0);
    pulse_stop();
    pulse_start();
    lit = "00000000"; chk("t4_restart_l0", c8[63:0], lit);
    cyc(2);

    // Async reset between edges
    #2 reset_n = 1'b0;
    #1;
    chk("t5_valid", {63'b0, v8}, 64'd0);
    chk("t5_busy", {63'b0, busy8}, 64'd0);
    chk("t5_mask", {61'b0, m8}, 64'd0);
    lit = "00000000"; chk("t5_lane1", c8[127:64], lit);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    pulse_start();
    lit = "00000001"; chk("t5_restart_l1", c8[127:64], lit);
    pulse_stop();

    // Exhaust the 2-digit space
    pulse_start();
    beats = 0; seen = '0; fin = 0;
    for (int t = 0; t < 60 && !fin; t++) begin
      if (v2) begin
        for (int k = 0; k < 3; k++)
          if (m2[k]) begin
            v = (int'(c2[k*16+8 +: 8]) - 48) * 10 + (int'(c2[k*16 +: 8]) - 48);
            if (v >= 0 && v < 100) seen[v] = 1'b1;
          end
        if (beats == 32) begin
          lit = "96"; chk("t3_b32_l0", {48'b0, c2[15:0]}, lit);
          lit = "98"; chk("t3_b32_l2", {48'b0, c2[47:32]}, lit);
          chk("t3_b32_mask", {61'b0, m2}, 64'd7);
        end
        if (beats == 33) begin
          lit = "99"; chk("t3_b33_l0", {48'b0, c2[15:0]}, lit);
          chk("t3_b33_mask", {61'b0, m2}, 64'd1);
        end
        beats++;
        cyc(1);
      end else fin = 1;
    end
    chk("t3_finished", {63'b0, fin}, 64'd1);
    chk("t3_beats", 64'(beats), 64'd34);
    distinct = $countones(seen);
    chk("t3_distinct", 64'(distinct), 64'd100);
    chk("t3_exh", {63'b0, exh2}, 64'd1);
`ifdef MD5_CAND_COUNT_EN
    chk("t6_cnt", {32'b0, n2}, 64'd100);
`endif
    pulse_stop();
    chk("t3_exh_after_stop", {63'b0, exh2}, 64'd1);
    pulse_start();
    lit = "00"; chk("t3_restart_l0", {48'b0, c2[15:0]}, lit);
    chk("t3_restart_exh", {63'b0, exh2}, 64'd0);
`ifdef MD5_CAND_COUNT_EN
    chk("t6_cnt_clr", {32'b0, n2}, 64'd0);
`endif
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
